// File: rtl/miscv_pkg.sv
// Shared types and constants for the 16-bit miscv core.
package miscv_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_ENC = 16'h0000;

    // Major opcodes live in instr[2:0]; their meaning is owned by the control decoder.
    localparam logic [2:0] OP_0 = 3'b000;
    localparam logic [2:0] OP_1 = 3'b001;
    localparam logic [2:0] OP_2 = 3'b010;
    localparam logic [2:0] OP_3 = 3'b011;
    localparam logic [2:0] OP_4 = 3'b100;
    localparam logic [2:0] OP_5 = 3'b101;
    localparam logic [2:0] OP_6 = 3'b110;
    localparam logic [2:0] OP_7 = 3'b111;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one request/accept handshake plus in-order read responses.
interface instr_fetch_if;
    import miscv_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats the stall/drain decision.
module if_id_reg
    import miscv_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               stall_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    input  logic [XLEN-1:0]    load_pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [XLEN-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [XLEN-1:0]    pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= load_instr_i;
            pc_q    <= load_pc_i;
        end else if (!stall_i) begin
            // Decode consumed the word and nothing replaces it: drain to a bubble.
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// miscv fetch stage: PC, single-outstanding imem reads, hold buffer and IF/ID register.
// Define FETCH_STALL_CNT_EN to add the saturating stall_cnt output.
module instr_fetch
    import miscv_pkg::*;
#(
    parameter logic [XLEN-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    instr_fetch_if.master      imem,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic               discard_q, discard_d;
    logic               req_q;

    logic               hs;
    logic               ifid_free;
    logic               ld;
    logic               flush;
    logic [INSTR_W-1:0] ld_instr;

    assign hs             = req_q & imem.imem_ready;
    assign ifid_free      = !id_valid | !stall_i;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        discard_d    = discard_q;
        ld           = 1'b0;
        flush        = 1'b0;
        ld_instr     = imem.imem_rdata;

        if (redirect_valid) begin
            pc_d         = align_pc(redirect_pc);
            flush        = 1'b1;
            hold_instr_d = NOP_INSTR;
            unique case (state_q)
                S_REQ: begin
                    // The request accepted this cycle is stale; its response must be dropped.
                    if (hs) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (hs) begin
                        pend_pc_d = pc_q;
                        pc_d      = pc_q + XLEN'(2);
                        state_d   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (ifid_free) begin
                            ld      = 1'b1;
                            state_d = S_REQ;
                        end else begin
                            hold_instr_d = imem.imem_rdata;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // pend_pc_q is still the held word's address: no request issues in S_HOLD.
                    if (!stall_i) begin
                        ld           = 1'b1;
                        ld_instr     = hold_instr_q;
                        hold_instr_d = NOP_INSTR;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
            discard_q    <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            discard_q    <= discard_d;
            req_q        <= (state_d == S_REQ);
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .load_i       (ld),
        .stall_i      (stall_i),
        .load_instr_i (ld_instr),
        .load_pc_i    (pend_pc_q),
        .valid_o      (id_valid),
        .instr_o      (id_instr),
        .pc_o         (id_pc)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        stall_cyc;

    assign stall_cyc = (state_q == S_WAIT) || (state_q == S_HOLD) ||
                       ((state_q == S_REQ) && req_q && !imem.imem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: dut a (RESET_PC=0) with a variable-latency memory,
// dut b (RESET_PC=FFFE) with a single-cycle memory for the wrap/wait-state case.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        no_stall;
    logic        no_redir;
    logic [15:0] no_redir_pc;

    logic        id_valid_a, id_valid_b;
    logic [15:0] id_instr_a, id_instr_b;
    logic [15:0] id_pc_a, id_pc_b;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_a, stall_cnt_b;
`endif

    int total = 0;
    int bad   = 0;

    int          lat;
    logic        busy;
    int          cnt;
    logic [15:0] paddr;

    instr_fetch_if ia();
    instr_fetch_if ib();

    instr_fetch u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (ia),
        .id_valid       (id_valid_a),
        .id_instr       (id_instr_a),
        .id_pc          (id_pc_a)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt_a)
`endif
    );

    instr_fetch #(
        .RESET_PC (16'hFFFE)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (no_stall),
        .redirect_valid (no_redir),
        .redirect_pc    (no_redir_pc),
        .imem           (ib),
        .id_valid       (id_valid_b),
        .id_instr       (id_instr_b),
        .id_pc          (id_pc_b)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1231;
        if (a == 16'h0002) return 16'h0452;
        return a ^ 16'h5A00;
    endfunction

    // Memory a: response visible lat cycles after the accepting edge.
    always @(posedge clk) begin
        ia.imem_rvalid <= 1'b0;
        if (rst) begin
            busy <= 1'b0;
            ia.imem_rdata <= 16'h0000;
        end else begin
            if (busy) begin
                if (cnt == 0) begin
                    ia.imem_rvalid <= 1'b1;
                    ia.imem_rdata  <= mem_word(paddr);
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (ia.imem_req && ia.imem_ready) begin
                if (lat <= 1) begin
                    ia.imem_rvalid <= 1'b1;
                    ia.imem_rdata  <= mem_word(ia.imem_addr);
                end else begin
                    busy  <= 1'b1;
                    cnt   <= lat - 2;
                    paddr <= ia.imem_addr;
                end
            end
        end
    end

    always @(posedge clk) begin
        ib.imem_rvalid <= !rst && ib.imem_req && ib.imem_ready;
        ib.imem_rdata  <= mem_word(ib.imem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        stall_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        no_stall       = 1'b0;
        no_redir       = 1'b0;
        no_redir_pc    = 16'h0000;
        lat            = 1;
        ia.imem_ready  = 1'b1;
        ib.imem_ready  = 1'b0;

        step();
        step();
        chk("rst_a_valid", {15'd0, id_valid_a}, 16'h0000);
        chk("rst_a_instr", id_instr_a, 16'h0000);
        chk("rst_a_pc", id_pc_a, 16'h0000);
        chk("rst_a_req", {15'd0, ia.imem_req}, 16'h0000);
        chk("rst_b_req", {15'd0, ib.imem_req}, 16'h0000);
        rst = 1'b0;

        step();
        chk("a_first_req", {15'd0, ia.imem_req}, 16'h0001);
        chk("a_first_addr", ia.imem_addr, 16'h0000);
        chk("b_first_addr", ib.imem_addr, 16'hFFFE);
        step();
        chk("a_wait_noreq", {15'd0, ia.imem_req}, 16'h0000);
        chk("b_addr_stable1", ib.imem_addr, 16'hFFFE);
        step();
        chk("a_w0_valid", {15'd0, id_valid_a}, 16'h0001);
        chk("a_w0_instr", id_instr_a, 16'h1231);
        chk("a_w0_pc", id_pc_a, 16'h0000);
        chk("a_second_addr", ia.imem_addr, 16'h0002);
        step();
        chk("b_addr_stable3", ib.imem_addr, 16'hFFFE);
        chk("b_req_held", {15'd0, ib.imem_req}, 16'h0001);
        ib.imem_ready = 1'b1;
        step();
        chk("a_w1_instr", id_instr_a, 16'h0452);
        chk("a_w1_pc", id_pc_a, 16'h0002);
        chk("b_wrap_addr", ib.imem_addr, 16'h0000);
`ifdef FETCH_STALL_CNT_EN
        chk("b_stall_cnt", stall_cnt_b, 16'd3);
`endif

        stall_i = 1'b1;
        step();
        chk("b_wrap_instr", id_instr_b, 16'hA5FE);
        chk("b_wrap_pc", id_pc_b, 16'hFFFE);
        chk("b_next_req", {15'd0, ib.imem_req}, 16'h0001);
        step();
        chk("a_hold_noreq", {15'd0, ia.imem_req}, 16'h0000);
        chk("a_hold_instr", id_instr_a, 16'h0452);
        step();
        step();
        chk("a_stall_valid", {15'd0, id_valid_a}, 16'h0001);
        chk("a_stall_instr", id_instr_a, 16'h0452);
        chk("a_stall_pc", id_pc_a, 16'h0002);
        chk("a_stall_noreq", {15'd0, ia.imem_req}, 16'h0000);
        stall_i = 1'b0;
        step();
        chk("a_release_instr", id_instr_a, 16'h5A04);
        chk("a_release_pc", id_pc_a, 16'h0004);
        chk("a_release_addr", ia.imem_addr, 16'h0006);

        lat = 3;
        step();
        chk("a_bubble_valid", {15'd0, id_valid_a}, 16'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        step();
        redirect_valid = 1'b0;
        chk("a_redir_flush", {15'd0, id_valid_a}, 16'h0000);
        step();
        step();
        chk("a_drop_valid", {15'd0, id_valid_a}, 16'h0000);
        chk("a_drop_req", {15'd0, ia.imem_req}, 16'h0001);
        chk("a_redir_addr", ia.imem_addr, 16'h0040);

        lat = 1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0080;
        step();
        redirect_valid = 1'b0;
        chk("a_simul_valid", {15'd0, id_valid_a}, 16'h0000);
        chk("a_simul_addr", ia.imem_addr, 16'h0080);
        step();
        step();
        chk("a_after_simul_instr", id_instr_a, 16'h5A80);
        chk("a_after_simul_pc", id_pc_a, 16'h0080);

        stall_i        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        redirect_valid = 1'b0;
        chk("a_redir_stall_valid", {15'd0, id_valid_a}, 16'h0000);
        chk("a_redir_stall_instr", id_instr_a, 16'h0000);
        step();
        chk("a_redir_stall_addr", ia.imem_addr, 16'h0100);
        chk("a_redir_stall_drop", {15'd0, id_valid_a}, 16'h0000);
        stall_i = 1'b0;
        step();
        step();
        chk("a_target_instr", id_instr_a, 16'h5B00);
        chk("a_target_pc", id_pc_a, 16'h0100);

        rst = 1'b1;
        step();
        chk("a_midrst_valid", {15'd0, id_valid_a}, 16'h0000);
        chk("a_midrst_instr", id_instr_a, 16'h0000);
        chk("a_midrst_pc", id_pc_a, 16'h0000);
        chk("a_midrst_req", {15'd0, ia.imem_req}, 16'h0000);
`ifdef FETCH_STALL_CNT_EN
        chk("a_midrst_cnt", stall_cnt_a, 16'd0);
`endif
        rst = 1'b0;
        step();
        chk("a_restart_req", {15'd0, ia.imem_req}, 16'h0001);
        chk("a_restart_addr", ia.imem_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
